// File: rtl/commit_arbiter_if.sv
// Commit-arbiter bus: per-source commit streams in, register-file writeback and retire out.
// COMMIT_ARB_PERF_EN adds the perf_stall/perf_lock counters to the bus.
interface commit_arbiter_if #(
  parameter int NUM_INPUTS    = 4,
  parameter int NW_WIDTH      = 2,
  parameter int SID_WIDTH     = 1,
  parameter int SIMD_WIDTH    = 4,
  parameter int XLEN          = 32,
  parameter int UUID_WIDTH    = 44,
  parameter int PC_BITS       = 30,
  parameter int NUM_REGS_BITS = 6
);
  localparam int DATAW = UUID_WIDTH + NW_WIDTH + SID_WIDTH + SIMD_WIDTH + PC_BITS + 1
                       + NUM_REGS_BITS + SIMD_WIDTH * XLEN + 2;

  logic [NUM_INPUTS-1:0]       in_valid;
  logic [NUM_INPUTS*DATAW-1:0] in_data;
  logic [NUM_INPUTS-1:0]       in_ready;
  logic                        wb_valid;
  logic [NW_WIDTH-1:0]         wb_wid;
  logic [SID_WIDTH-1:0]        wb_sid;
  logic [SIMD_WIDTH-1:0]       wb_tmask;
  logic [NUM_REGS_BITS-1:0]    wb_rd;
  logic [SIMD_WIDTH*XLEN-1:0]  wb_data;
  logic                        wb_ready;
  logic                        retire_valid;
  logic [NW_WIDTH-1:0]         retire_wid;
  logic [63:0]                 instret;
`ifdef COMMIT_ARB_PERF_EN
  logic [63:0]                 perf_stall;
  logic [63:0]                 perf_lock;
`endif

  modport master (
    output in_valid, in_data, wb_ready,
    input  in_ready, wb_valid, wb_wid, wb_sid, wb_tmask, wb_rd, wb_data,
    input  retire_valid, retire_wid, instret
`ifdef COMMIT_ARB_PERF_EN
    , input perf_stall, perf_lock
`endif
  );

  modport slave (
    input  in_valid, in_data, wb_ready,
    output in_ready, wb_valid, wb_wid, wb_sid, wb_tmask, wb_rd, wb_data,
    output retire_valid, retire_wid, instret
`ifdef COMMIT_ARB_PERF_EN
    , output perf_stall, perf_lock
`endif
  );
endinterface

// File: rtl/commit_arbiter.sv
// Round-robin commit arbiter with eop-locking, single output register, retire pulse and instret.
// Define COMMIT_ARB_PERF_EN to add the perf_stall/perf_lock cycle counters.
module commit_arbiter #(
  parameter int NUM_INPUTS    = 4,
  parameter int NW_WIDTH      = 2,
  parameter int SID_WIDTH     = 1,
  parameter int SIMD_WIDTH    = 4,
  parameter int XLEN          = 32,
  parameter int UUID_WIDTH    = 44,
  parameter int PC_BITS       = 30,
  parameter int NUM_REGS_BITS = 6
) (
  input logic             clk,
  input logic             reset,
  commit_arbiter_if.slave bus
);
  localparam int DATAW = UUID_WIDTH + NW_WIDTH + SID_WIDTH + SIMD_WIDTH + PC_BITS + 1
                       + NUM_REGS_BITS + SIMD_WIDTH * XLEN + 2;
  localparam int SRC_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int OFF_EOP   = 0;
  localparam int OFF_SOP   = 1;
  localparam int OFF_DATA  = 2;
  localparam int OFF_RD    = OFF_DATA + SIMD_WIDTH * XLEN;
  localparam int OFF_WB    = OFF_RD + NUM_REGS_BITS;
  localparam int OFF_PC    = OFF_WB + 1;
  localparam int OFF_TMASK = OFF_PC + PC_BITS;
  localparam int OFF_SID   = OFF_TMASK + SIMD_WIDTH;
  localparam int OFF_WID   = OFF_SID + SID_WIDTH;
  localparam int OFF_UUID  = OFF_WID + NW_WIDTH;

  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t              state_q, state_n;
  logic [SRC_W-1:0]         lock_src_q, lock_src_n;
  logic [SRC_W-1:0]         rr_q, rr_n;
  logic [SRC_W-1:0]         grant;
  logic                     found, accept, handshake, drain;
  logic [DATAW-1:0]         src_pkt [NUM_INPUTS];
  logic [DATAW-1:0]         pkt;
  logic                     vld_p1;
  logic [NW_WIDTH-1:0]      wid_p1;
  logic [SID_WIDTH-1:0]     sid_p1;
  logic [SIMD_WIDTH-1:0]    tmask_p1;
  logic [NUM_REGS_BITS-1:0] rd_p1;
  logic [SIMD_WIDTH*XLEN-1:0] data_p1;
  logic                     wb_p1, eop_p1;
  logic [63:0]              instret_q;
  logic                     unused_fields;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_split
    assign src_pkt[i] = bus.in_data[i*DATAW +: DATAW];
  end

  assign pkt           = src_pkt[grant];
  assign unused_fields = ^{pkt[OFF_UUID +: UUID_WIDTH], pkt[OFF_PC +: PC_BITS]};

  // A held wb=0 packet never waits on the register file, so it always frees the slot.
  assign accept    = !vld_p1 || bus.wb_ready || !wb_p1;
  assign drain     = vld_p1 && (bus.wb_ready || !wb_p1);
  assign handshake = found && bus.in_valid[grant] && accept;

  always_comb begin
    int idx;
    idx   = 0;
    grant = rr_q;
    found = 1'b0;
    if (state_q == LOCKED) begin
      grant = lock_src_q;
      found = 1'b1;
    end else begin
      // Walk downward so the last hit is the first valid source at or after rr_q.
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        idx = int'(rr_q) + i;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
        if (bus.in_valid[SRC_W'(idx)]) begin
          grant = SRC_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (found) bus.in_ready[grant] = accept;
  end

  always_comb begin
    state_n    = state_q;
    lock_src_n = lock_src_q;
    rr_n       = rr_q;
    case (state_q)
      IDLE: begin
        if (handshake && pkt[OFF_SOP] && !pkt[OFF_EOP]) begin
          state_n    = LOCKED;
          lock_src_n = grant;
        end
      end
      LOCKED: begin
        if (handshake && pkt[OFF_EOP]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (handshake && state_n == IDLE)
      rr_n = (grant == SRC_W'(NUM_INPUTS - 1)) ? '0 : grant + SRC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_src_q <= '0;
      rr_q       <= '0;
      vld_p1     <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_n;
      lock_src_q <= lock_src_n;
      rr_q       <= rr_n;
      vld_p1     <= handshake | (vld_p1 & ~drain);
      instret_q  <= instret_q + 64'(drain && eop_p1);
    end
  end

  // ---- p0 -> p1: granted packet captured into the output register ----
  always_ff @(posedge clk) begin
    if (handshake) begin
      wid_p1   <= pkt[OFF_WID +: NW_WIDTH];
      sid_p1   <= pkt[OFF_SID +: SID_WIDTH];
      tmask_p1 <= pkt[OFF_TMASK +: SIMD_WIDTH];
      rd_p1    <= pkt[OFF_RD +: NUM_REGS_BITS];
      data_p1  <= pkt[OFF_DATA +: SIMD_WIDTH*XLEN];
      wb_p1    <= pkt[OFF_WB];
      eop_p1   <= pkt[OFF_EOP];
    end
  end

  assign bus.wb_valid     = vld_p1 && wb_p1;
  assign bus.wb_wid       = wid_p1;
  assign bus.wb_sid       = sid_p1;
  assign bus.wb_tmask     = tmask_p1;
  assign bus.wb_rd        = rd_p1;
  assign bus.wb_data      = data_p1;
  assign bus.retire_valid = drain && eop_p1;
  assign bus.retire_wid   = wid_p1;
  assign bus.instret      = instret_q;

`ifdef COMMIT_ARB_PERF_EN
  logic [63:0] perf_stall_q, perf_lock_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_lock_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + 64'(bus.wb_valid && !bus.wb_ready);
      perf_lock_q  <= perf_lock_q + 64'(state_q == LOCKED && !bus.in_valid[lock_src_q]);
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_lock  = perf_lock_q;
`endif
endmodule
